// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: exception codes, default address map, F-side bundle.
package fetch_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_EXC_ENTRY = 32'h0000_4180;
  localparam logic [XLEN-1:0] DEF_IM_BASE   = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_IM_LIMIT  = 32'h0000_6FFC;

  // Payload latched by the F-to-D pipeline register.
  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [EXC_W-1:0] exc_code;
    logic             bd;
  } f_bundle_t;

endpackage

// File: rtl/fetch_stage_npc_sel.sv
// Next-PC priority mux: exception entry, eret, stall hold, D-stage redirect, sequential.
module fetch_stage_npc_sel
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_ENTRY = DEF_EXC_ENTRY
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_req_exc,
  input  logic            i_eret,
  input  logic [XLEN-1:0] i_epc,
  output logic [XLEN-1:0] o_npc_c
);

  logic [XLEN-1:0] w_seq_pc;

  assign w_seq_pc = i_pc + XLEN'(4);

  // Exception and eret override stall; a stalled redirect is re-presented by D.
  always_comb begin
    o_npc_c = w_seq_pc;
    if (i_req_exc) begin
      o_npc_c = EXC_ENTRY;
    end else if (i_eret) begin
      o_npc_c = i_epc;
    end else if (i_stall) begin
      o_npc_c = i_pc;
    end else if (i_redirect) begin
      o_npc_c = i_redirect_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select, AdEL check and F-side bundle to the F-to-D register.
// Optional fetched-instruction counter on fetch_cnt when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] EXC_ENTRY = DEF_EXC_ENTRY,
  parameter logic [XLEN-1:0] IM_BASE   = DEF_IM_BASE,
  parameter logic [XLEN-1:0] IM_LIMIT  = DEF_IM_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_D,
  input  logic [XLEN-1:0]  redirect_pc_D,
  input  logic             is_jump_D,
  input  logic             req_exc,
  input  logic             eret,
  input  logic [XLEN-1:0]  epc,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  pc_F,
  output logic [XLEN-1:0]  npc,
  output logic [XLEN-1:0]  instr_F,
  output logic [EXC_W-1:0] excCode_F,
  output logic             BD_F
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0]  fetch_cnt
`endif
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_npc;
  logic            w_adel;
  f_bundle_t       w_bundle;

  fetch_stage_npc_sel #(
    .EXC_ENTRY (EXC_ENTRY)
  ) u_npc_sel (
    .i_pc          (r_pc),
    .i_stall       (stall),
    .i_redirect    (redirect_D),
    .i_redirect_pc (redirect_pc_D),
    .i_req_exc     (req_exc),
    .i_eret        (eret),
    .i_epc         (epc),
    .o_npc_c       (w_npc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_npc;
    end
  end

  // Misaligned or outside the instruction memory window.
  assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);

  // A flushed slot (exception entry or eret) is never a delay slot.
  always_comb begin
    w_bundle.pc       = r_pc;
    w_bundle.instr    = imem_rdata;
    w_bundle.exc_code = EXC_NONE;
    w_bundle.bd       = is_jump_D && !req_exc && !eret;
    if (w_adel) begin
      w_bundle.instr    = '0;
      w_bundle.exc_code = EXC_ADEL;
    end
  end

  assign imem_addr = r_pc;
  assign pc_F      = w_bundle.pc;
  assign npc       = w_npc;
  assign instr_F   = w_bundle.instr;
  assign excCode_F = w_bundle.exc_code;
  assign BD_F      = w_bundle.bd;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] r_fetch_cnt;
  logic            w_load;

  assign w_load = !stall || req_exc || eret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
    end else if (w_load) begin
      r_fetch_cnt <= r_fetch_cnt + XLEN'(1);
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic against a PC model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_D, is_jump_D, req_exc, eret;
  logic [31:0] redirect_pc_D, epc, imem_rdata;
  logic [31:0] imem_addr, pc_F, npc, instr_F;
  logic [4:0]  excCode_F;
  logic        BD_F;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  // Instruction memory stand-in: data is a recognisable function of the address.
  assign imem_rdata = {imem_addr[15:0], ~imem_addr[15:0]};

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_D    (redirect_D),
    .redirect_pc_D (redirect_pc_D),
    .is_jump_D     (is_jump_D),
    .req_exc       (req_exc),
    .eret          (eret),
    .epc           (epc),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .pc_F          (pc_F),
    .npc           (npc),
    .instr_F       (instr_F),
    .excCode_F     (excCode_F),
    .BD_F          (BD_F)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_window(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h6FFC);
  endfunction

  // Apply one cycle of inputs, check all F-side outputs against the model, then clock.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic jmp,
                       input logic ex, input logic er, input logic [31:0] ep);
    logic [31:0] e_npc;
    logic        bad;
    stall = st; redirect_D = rd; redirect_pc_D = rpc; is_jump_D = jmp;
    req_exc = ex; eret = er; epc = ep;
    #1;
    if (ex)       e_npc = 32'h4180;
    else if (er)  e_npc = ep;
    else if (st)  e_npc = m_pc;
    else if (rd)  e_npc = rpc;
    else          e_npc = m_pc + 32'd4;
    bad = !in_window(m_pc);
    check("pc_F",      pc_F,      m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("npc",       npc,       e_npc);
    check("instr_F",   instr_F,   bad ? 32'h0 : {m_pc[15:0], ~m_pc[15:0]});
    check("excCode_F", {27'd0, excCode_F}, bad ? 32'd4 : 32'd0);
    check("BD_F",      {31'd0, BD_F}, {31'd0, jmp && !ex && !er});
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, m_cnt);
`endif
    @(posedge clk);
    m_pc = e_npc;
    if (!st || ex || er) m_cnt = m_cnt + 32'd1;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'h3000 + (32'($urandom_range(0, 32'h0FFF)) << 2);
    case ($urandom_range(0, 7))
      0: t = t | 32'($urandom_range(1, 3));
      1: t = 32'h2FFC;
      2: t = 32'h7000;
      default: ;
    endcase
    return t;
  endfunction

  initial begin
    reset = 1'b0;
    stall = 0; redirect_D = 0; is_jump_D = 0; req_exc = 0; eret = 0;
    redirect_pc_D = 0; epc = 0;
    m_pc = 32'h3000; m_cnt = 0;
    #12;
    check("rst_pc_F", pc_F, 32'h3000);
    check("rst_npc", npc, 32'h3004);
    check("rst_exc", {27'd0, excCode_F}, 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_cnt", fetch_cnt, 32'd0);
`endif
    reset = 1'b1;

    // Sequential advance 0x3000 -> 0x3010.
    repeat (4) idle();
    check("seq_pc", pc_F, 32'h3010);
    // Two stalled cycles hold the PC.
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("stall_pc", pc_F, 32'h3010);
    idle();
    // Branch with delay slot at 0x3014.
    check("br_at", pc_F, 32'h3014);
    cycle(1'b0, 1'b1, 32'h3100, 1'b1, 1'b0, 1'b0, 32'h0);
    check("br_tgt", pc_F, 32'h3100);
    idle();
    // Misaligned jr target, then below-window target.
    cycle(1'b0, 1'b1, 32'h3102, 1'b1, 1'b0, 1'b0, 32'h0);
    check("mis_exc", {27'd0, excCode_F}, 32'd4);
    check("mis_instr", instr_F, 32'h0);
    cycle(1'b0, 1'b1, 32'h2FFC, 1'b0, 1'b0, 1'b0, 32'h0);
    check("low_exc", {27'd0, excCode_F}, 32'd4);
    // Exception beats stall, eret and redirect.
    cycle(1'b1, 1'b1, 32'h3200, 1'b1, 1'b1, 1'b1, 32'h3040);
    check("exc_pc", pc_F, 32'h4180);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3040);
    check("eret_pc", pc_F, 32'h3040);
    // Top-of-space wrap.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle();
    check("wrap_pc", pc_F, 32'h0);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rand_target(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, rand_target());
    end

    // Reset asserted mid-stall/redirect takes effect without a clock edge.
    stall = 1; redirect_D = 1; redirect_pc_D = 32'h3500; #2;
    reset = 1'b0;
    #1;
    check("midrst_pc", pc_F, 32'h3000);
`ifdef FETCH_PERF_EN
    check("midrst_cnt", fetch_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    check("rst_hold_pc", pc_F, 32'h3000);
    stall = 0; redirect_D = 0; #1;
    check("midrst_npc", npc, 32'h3004);
    reset = 1'b1;
    m_pc = 32'h3000; m_cnt = 0;
    repeat (3) idle();
    check("post_rst_pc", pc_F, 32'h300C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
